list_closest_hit: RTL and testbench
===================================

// Module: list_closest_hit
// PURPOSE
// - Consumes intersection results (int_to_list_t) from the intersection unit; keeps, per ray, the closest hit seen so far.
// - On a ray's last-triangle result, emits one final record (closest hit or miss) downstream to shading, then frees that ray's slot.
// - Sits directly after the intersection unit's list FIFO. Accepts one record per cycle.
// PARAMETERS
// - RAYID_W   9  width of ray_info.rayID; table depth = 2**RAYID_W
// - OUT_DEPTH 4  output buffer entries; must be >= 3
// PORTS
// - clk                 in   1     single clock
// - rst                 in   1     synchronous, active-high reset
// - int_to_list_valid   in   1     upstream record valid
// - int_to_list_data    in   int_to_list_t  {ray_info, triID, hit, is_last, t_int, uv}
// - int_to_list_stall   out  1     upstream must hold record
// - list_to_ss_valid    out  1     final record valid
// - list_to_ss_data     out  list_to_ss_t  {ray_info, hit, triID, t_int, uv}
// - list_to_ss_stall    in   1     downstream back-pressure
// BEHAVIOUR
// - Handshake, both sides: transfer = valid & ~stall. Valid and data are held while stalled.
// - Reset: list_to_ss_valid=0; int_to_list_stall=0; all table entries invalid; pipeline and buffer emptied.
// - Reset mid-operation discards every partial ray and in-flight record. Nothing is emitted for discarded rays.
// - Table entry per rayID: {occ, t_int, triID, uv}.
//   - occ bits are a flop vector cleared in one cycle.
//   - Data fields are held in RAM with a registered read.
// - S0 (accept cycle): issue RAM read at rayID; register the record.
// - S1 (next cycle): form cur = occ ? stored : none.
//   - Forwarding: if the previous S1 wrote the same rayID, cur = that write (back-to-back same-ray must be correct).
//   - closer = hit & (~cur.occ | t_int < cur.t_int).
//   - t_int is positive IEEE float, so compare as 32-bit unsigned.
//   - Tie: keep the stored (earlier) hit.
// - S1 action when ~is_last:
//   - If closer, write {occ=1, t_int, triID, uv}.
//   - Otherwise no change.
//   - A record with hit=0 & is_last=0 is a legal no-op.
// - S1 action when is_last:
//   - best = closer ? incoming : cur.
//   - Push {ray_info, hit=best valid, triID, t_int, uv} into the output buffer.
//   - Miss: hit=0, triID=0, t_int=0, uv=0.
//   - Clear occ[rayID] in the same cycle.
// - Latency: is_last accepted in cycle N gives list_to_ss_valid in cycle N+2 (buffer empty, no stall).
// - Output buffer: FIFO of OUT_DEPTH entries. list_to_ss_valid = ~empty. Pop on list_to_ss_valid & ~list_to_ss_stall.
// - Flow control, no overflow:
//   - int_to_list_stall = (buf_count + s0_v + s1_v) >= OUT_DEPTH.
//   - This is conservative, since non-last records never need a slot.
//   - Simultaneous push and pop in the same cycle leave the count unchanged.
// - Order: outputs leave in is_last acceptance order. Rays are independent; interleaving of rayIDs is arbitrary.
// - Assertions (non-SYNTH builds): no push while buffer full; no occ bit set for a ray whose is_last was already emitted without a later record for that ray.
// STRUCTURE
// - Shared package additions:
//   - list_to_ss_t
//   - RAYID_W-consistent rayID_t
//   - constant FLOAT_ZERO
//   - int_to_list_t stays as already defined.
// - One sub-module: list_hit_ram, a simple dual-port RAM.
//   - Depth 2**RAYID_W; width {triID, t_int, uv}.
//   - 1-cycle registered read; write-first not required, because forwarding covers it.
// - Output buffer uses the codebase's existing small register FIFO. No new module.
// TESTING
// - Single ray 5: hits t=3.0, 1.5, 2.0 (triIDs 10, 11, 12); last record hit=0
//   -> one output: hit=1, triID=11, t=1.5.
// - Ray 7: only record is_last=1, hit=0 -> output hit=0, triID=0, t=0; occ[7]=0 afterwards.
// - Back-to-back ray 3 records on consecutive cycles: t=4.0, then t=2.0 with is_last=1
//   -> triID of the t=2.0 record is emitted (forwarding path).
// - Tie: ray 9, t=1.0 triID 20, then t=1.0 triID 21 last -> triID 20 emitted.
// - Hold list_to_ss_stall=1 for 20 cycles while streaming is_last for rays 0..9:
//   -> int_to_list_stall rises once buf_count+in-flight reaches 4
//   -> no loss, no duplicate; rays 0..9 emitted in order after release.
// - Assert rst mid-stream with rays 1, 2 partial
//   -> outputs invalid next cycle; ray 1 restarted with a single last miss emits hit=0 (old hit forgotten).

Source files
------------

// File: rtl/list_closest_hit_pkg.sv
// list_closest_hit_pkg: shared types and helpers for the closest-hit list stage
package list_closest_hit_pkg;
   localparam int RAYID_W = 9;
   localparam int TRI_W = 16;
   typedef logic [RAYID_W-1:0] rayID_t;
   typedef logic [31:0] float_t;
   localparam float_t FLOAT_ZERO = 32'h0000_0000;
   typedef struct packed {
      rayID_t rayID;
   } ray_info_t;
   typedef struct packed {
      logic [15:0] u;
      logic [15:0] v;
   } uv_t;
   typedef struct packed {
      ray_info_t ray_info;
      logic [TRI_W-1:0] triID;
      logic hit;
      logic is_last;
      float_t t_int;
      uv_t uv;
   } int_to_list_t;
   typedef struct packed {
      ray_info_t ray_info;
      logic hit;
      logic [TRI_W-1:0] triID;
      float_t t_int;
      uv_t uv;
   } list_to_ss_t;
   typedef struct packed {
      logic [TRI_W-1:0] triID;
      float_t t_int;
      uv_t uv;
   } hit_rec_t;
   localparam hit_rec_t MISS_REC = '{triID: '0, t_int: FLOAT_ZERO, uv: '0};
   function automatic logic is_closer(input logic hit, input logic occ, input float_t t, input float_t cur_t);
      return hit & (~occ | (t < cur_t));
   endfunction
endpackage

// File: rtl/list_closest_hit_if.sv
// list_closest_hit_if: upstream intersection and downstream shading handshakes
interface list_closest_hit_if;
   import list_closest_hit_pkg::*;
   logic int_to_list_valid;
   int_to_list_t int_to_list_data;
   logic int_to_list_stall;
   logic list_to_ss_valid;
   list_to_ss_t list_to_ss_data;
   logic list_to_ss_stall;
   modport master (
      output int_to_list_valid, int_to_list_data, list_to_ss_stall,
      input int_to_list_stall, list_to_ss_valid, list_to_ss_data
   );
   modport slave (
      input int_to_list_valid, int_to_list_data, list_to_ss_stall,
      output int_to_list_stall, list_to_ss_valid, list_to_ss_data
   );
endinterface

// File: rtl/list_closest_hit_ram.sv
// list_hit_ram: per-ray best-hit storage, one write port and one registered read port
module list_hit_ram
   import list_closest_hit_pkg::*;
(
   input logic clk,
   input logic we,
   input rayID_t waddr,
   input hit_rec_t wdata,
   input logic re,
   input rayID_t raddr,
   output hit_rec_t rdata
);
   hit_rec_t mem_q [2**RAYID_W];
   hit_rec_t rdata_q;
   assign rdata = rdata_q;
   // write the new best and read the next record's entry; same-address hazards are forwarded by the caller
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
      if (re) rdata_q <= mem_q[raddr];
   end
endmodule

// File: rtl/list_closest_hit.sv
// list_closest_hit: tracks the closest hit per ray and emits one final record per ray
module list_closest_hit
   import list_closest_hit_pkg::*;
#(
   parameter int OUT_DEPTH = 4
) (
   input logic clk,
   input logic rst,
   list_closest_hit_if.slave bus
);
   localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CW = $clog2(OUT_DEPTH + 1);
   localparam int NRAY = 2 ** RAYID_W;
   logic accept, cur_occ, closer, we, push, pop;
   logic s1_v_q, s1_v_d;
   int_to_list_t s1_rec_q, s1_rec_d;
   logic [NRAY-1:0] occ_q, occ_d;
   logic fwd_v_q, fwd_v_d;
   rayID_t fwd_id_q, fwd_id_d, id;
   hit_rec_t fwd_rec_q, fwd_rec_d, inc, cur, ram_rd, best;
   list_to_ss_t out_rec;
   list_to_ss_t buf_q [OUT_DEPTH];
   list_to_ss_t buf_d [OUT_DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction
   assign accept = bus.int_to_list_valid & ~bus.int_to_list_stall;
   assign bus.int_to_list_stall = (int'(cnt_q) + int'(s1_v_q)) >= OUT_DEPTH;
   assign bus.list_to_ss_valid = cnt_q != '0;
   assign bus.list_to_ss_data = buf_q[rd_q];
   list_hit_ram u_ram (
      .clk(clk),
      .we(we),
      .waddr(id),
      .wdata(inc),
      .re(accept),
      .raddr(bus.int_to_list_data.ray_info.rayID),
      .rdata(ram_rd)
   );
   // merge the registered record with the stored best, taking last cycle's write when it hit the same ray
   always_comb begin
      id = s1_rec_q.ray_info.rayID;
      inc = {s1_rec_q.triID, s1_rec_q.t_int, s1_rec_q.uv};
      cur_occ = occ_q[id];
      cur = (fwd_v_q && fwd_id_q == id) ? fwd_rec_q : ram_rd;
      closer = is_closer(s1_rec_q.hit, cur_occ, s1_rec_q.t_int, cur.t_int);
      we = s1_v_q & ~s1_rec_q.is_last & closer;
      push = s1_v_q & s1_rec_q.is_last;
      best = closer ? inc : cur_occ ? cur : MISS_REC;
      out_rec = {s1_rec_q.ray_info, closer | cur_occ, best.triID, best.t_int, best.uv};
   end
   // next state for pipeline, occupancy, forwarding and the output buffer
   always_comb begin
      s1_v_d = accept;
      s1_rec_d = bus.int_to_list_data;
      occ_d = occ_q;
      if (we) occ_d[id] = 1'b1;
      if (push) occ_d[id] = 1'b0;
      fwd_v_d = we;
      fwd_id_d = id;
      fwd_rec_d = inc;
      pop = bus.list_to_ss_valid & ~bus.list_to_ss_stall;
      buf_d = buf_q;
      if (push) buf_d[wr_q] = out_rec;
      wr_d = push ? nxt(wr_q) : wr_q;
      rd_d = pop ? nxt(rd_q) : rd_q;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
   end
   // state registers; reset drops every partial ray and in-flight record
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v_q <= 1'b0;
         occ_q <= '0;
         fwd_v_q <= 1'b0;
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         s1_v_q <= s1_v_d;
         occ_q <= occ_d;
         fwd_v_q <= fwd_v_d;
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
      end
      s1_rec_q <= s1_rec_d;
      fwd_id_q <= fwd_id_d;
      fwd_rec_q <= fwd_rec_d;
      buf_q <= buf_d;
   end
`ifndef SYNTH
   // flow control must prevent overflow, and a finished ray must not keep its slot
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         assert (cnt_q != CW'(OUT_DEPTH)) else $error("push into full output buffer");
         assert (!occ_d[id]) else $error("occupancy kept after last record of ray %0d", id);
      end
   end
`endif
endmodule

// File: tb/tb_list_closest_hit.sv
// tb_list_closest_hit: directed and scoreboard checks for the closest-hit list stage
module tb_list_closest_hit;
   import list_closest_hit_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   bit saw_stall = 1'b0;
   list_to_ss_t exp_q [$];
   logic m_occ [2**RAYID_W];
   hit_rec_t m_rec [2**RAYID_W];
   list_closest_hit_if bus ();
   list_closest_hit dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask
   task automatic model_reset();
      for (int i = 0; i < 2**RAYID_W; i++) m_occ[i] = 1'b0;
      exp_q.delete();
   endtask
   task automatic send(input int id, input int tid, input bit hit, input bit last, input float_t t);
      int_to_list_t r;
      list_to_ss_t e;
      logic st;
      logic cl;
      int n = 0;
      r.ray_info.rayID = rayID_t'(id);
      r.triID = 16'(tid);
      r.hit = hit;
      r.is_last = last;
      r.t_int = t;
      r.uv = {16'(tid), ~16'(tid)};
      bus.int_to_list_valid = 1'b1;
      bus.int_to_list_data = r;
      do begin
         st = bus.int_to_list_stall;
         if (st) saw_stall = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end while (st && n < 300);
      bus.int_to_list_valid = 1'b0;
      if (st) chk("send_timeout", st, 1'b0);
      else begin
         cl = hit && (!m_occ[id] || t < m_rec[id].t_int);
         if (last) begin
            e = cl ? {r.ray_info, 1'b1, r.triID, r.t_int, r.uv} :
                m_occ[id] ? {r.ray_info, 1'b1, m_rec[id].triID, m_rec[id].t_int, m_rec[id].uv} :
                {r.ray_info, 1'b0, 16'd0, FLOAT_ZERO, 32'd0};
            exp_q.push_back(e);
            m_occ[id] = 1'b0;
         end else if (cl) begin
            m_occ[id] = 1'b1;
            m_rec[id] = {r.triID, r.t_int, r.uv};
         end
      end
   endtask
   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      chk("drain", exp_q.size(), 0);
   endtask
   task automatic after_last(input string tag, input bit hit, input int tid, input float_t t);
      chk({tag, "_early"}, bus.list_to_ss_valid, 1'b0);
      @(posedge clk);
      #1;
      chk({tag, "_valid"}, bus.list_to_ss_valid, 1'b1);
      chk({tag, "_hit"}, bus.list_to_ss_data.hit, hit);
      chk({tag, "_tri"}, bus.list_to_ss_data.triID, 16'(tid));
      chk({tag, "_t"}, bus.list_to_ss_data.t_int, t);
   endtask
   always @(negedge clk) begin
      if (!rst && bus.list_to_ss_valid && !bus.list_to_ss_stall) begin
         chk("out_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) chk("out_rec", bus.list_to_ss_data, exp_q.pop_front());
      end
   end
   initial begin
      bus.int_to_list_valid = 1'b0;
      bus.int_to_list_data = '0;
      bus.list_to_ss_stall = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_valid", bus.list_to_ss_valid, 1'b0);
      chk("reset_stall", bus.int_to_list_stall, 1'b0);
      send(5, 10, 1, 0, 32'h4040_0000);
      send(5, 11, 1, 0, 32'h3FC0_0000);
      send(5, 12, 1, 0, 32'h4000_0000);
      send(5, 0, 0, 1, 32'h0);
      after_last("ray5", 1, 11, 32'h3FC0_0000);
      wait_drain();
      send(7, 77, 0, 1, 32'h4000_0000);
      after_last("ray7", 0, 0, FLOAT_ZERO);
      chk("ray7_occ", dut.occ_q[7], 1'b0);
      wait_drain();
      send(3, 30, 1, 0, 32'h4080_0000);
      send(3, 31, 1, 1, 32'h4000_0000);
      after_last("ray3_fwd_a", 1, 31, 32'h4000_0000);
      wait_drain();
      send(3, 32, 1, 0, 32'h4000_0000);
      send(3, 33, 1, 1, 32'h4080_0000);
      after_last("ray3_fwd_b", 1, 32, 32'h4000_0000);
      wait_drain();
      send(9, 20, 1, 0, 32'h3F80_0000);
      send(9, 21, 1, 1, 32'h3F80_0000);
      after_last("ray9_tie", 1, 20, 32'h3F80_0000);
      wait_drain();
      bus.list_to_ss_stall = 1'b1;
      saw_stall = 1'b0;
      fork
         begin
            repeat (20) @(posedge clk);
            #1;
            chk("held_in_stall", bus.int_to_list_stall, 1'b1);
            chk("held_out_valid", bus.list_to_ss_valid, 1'b1);
            bus.list_to_ss_stall = 1'b0;
         end
         begin
            for (int k = 0; k < 10; k++) send(k, 100 + k, 1, 1, 32'h3F80_0000 + 32'(k << 20));
         end
      join
      chk("stall_seen", saw_stall, 1'b1);
      wait_drain();
      bus.list_to_ss_stall = 1'b1;
      send(1, 40, 1, 0, 32'h4000_0000);
      send(2, 41, 1, 0, 32'h3F80_0000);
      send(6, 42, 1, 1, 32'h4040_0000);
      @(posedge clk);
      #1;
      chk("pre_reset_valid", bus.list_to_ss_valid, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_reset_valid", bus.list_to_ss_valid, 1'b0);
      chk("mid_reset_stall", bus.int_to_list_stall, 1'b0);
      chk("mid_reset_occ1", dut.occ_q[1], 1'b0);
      model_reset();
      rst = 1'b0;
      bus.list_to_ss_stall = 1'b0;
      send(1, 0, 0, 1, 32'h0);
      after_last("ray1_restart", 0, 0, FLOAT_ZERO);
      wait_drain();
      send(2, 43, 1, 1, 32'h40A0_0000);
      after_last("ray2_restart", 1, 43, 32'h40A0_0000);
      wait_drain();
      for (int k = 0; k < 60; k++) begin
         bus.list_to_ss_stall = $urandom_range(0, 3) == 0;
         send(20 + int'($urandom_range(0, 3)), 200 + k, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
              32'h3F80_0000 + 32'($urandom_range(0, 3) << 22));
      end
      for (int k = 20; k < 24; k++) send(k, 300 + k, 0, 1, 32'h0);
      bus.list_to_ss_stall = 1'b0;
      wait_drain();
      chk("final_idle", bus.list_to_ss_valid, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
